// File: rtl/tlb_mmu_ctrl.sv
// Direct-mapped TLB controller that owns the MMU entry RAM port.
// It serves lookups, accepts page-walker fills and sweeps the RAM clean on flush.
module tlb_mmu_ctrl #(
  parameter int abits   = 6,
  parameter int dbits   = 104,
  parameter int vpnbits = 27,
  parameter int ppnbits = 44
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  input  logic [vpnbits-1:0] i_req_vpn,
  output logic               o_req_ready,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic               o_resp_hit,
  output logic [ppnbits-1:0] o_resp_ppn,
  output logic [7:0]         o_resp_flags,
  input  logic               i_fill_valid,
  input  logic [vpnbits-1:0] i_fill_vpn,
  input  logic [ppnbits-1:0] i_fill_ppn,
  input  logic [7:0]         i_fill_flags,
  output logic               o_fill_ready,
  input  logic               i_flush_valid,
  output logic               o_flush_busy,
  output logic [abits-1:0]   o_mem_addr,
  output logic               o_mem_wena,
  output logic [dbits-1:0]   o_mem_wdata,
  input  logic [dbits-1:0]   i_mem_rdata
);

  localparam int DEPTH   = 2**abits;
  localparam int TAGW    = vpnbits - abits;
  localparam int TAG_LSB = dbits - 1 - TAGW;
  localparam int PPN_LSB = TAG_LSB - ppnbits;
  localparam int FLG_LSB = PPN_LSB - 8;

  localparam logic [abits-1:0] CNT_LAST = abits'(DEPTH - 1);
  localparam logic [abits-1:0] CNT_ONE  = abits'(1);

  localparam logic [1:0] S_FLUSH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state;
  logic [abits-1:0]   cnt;
  logic               flush_pend;
  logic [TAGW-1:0]    tag_p0;
  logic               hit_p1;
  logic [ppnbits-1:0] ppn_p1;
  logic [7:0]         flags_p1;

  logic               idle_free;
  logic               fill_take;
  logic               req_take;
  logic               rd_hit;
  logic               unused_rdata;

  function automatic logic [dbits-1:0] pack_entry(
    input logic [TAGW-1:0]    tag,
    input logic [ppnbits-1:0] ppn,
    input logic [7:0]         flags
  );
    logic [dbits-1:0] e;
    e = '0;
    e[dbits-1]           = 1'b1;
    e[TAG_LSB +: TAGW]   = tag;
    e[PPN_LSB +: ppnbits] = ppn;
    e[FLG_LSB +: 8]      = flags;
    return e;
  endfunction

  // Fill wins over lookup; a pending or incoming flush blocks both.
  assign idle_free   = !i_rst && (state == S_IDLE) && !i_flush_valid && !flush_pend;
  assign fill_take   = idle_free && i_fill_valid;
  assign req_take    = idle_free && !i_fill_valid && i_req_valid;
  assign o_fill_ready = fill_take;
  assign o_req_ready  = req_take;

  assign o_flush_busy = flush_pend | i_flush_valid | (state == S_FLUSH);
  assign o_resp_valid = !i_rst && (state == S_RESP);
  assign o_resp_hit   = hit_p1;
  assign o_resp_ppn   = ppn_p1;
  assign o_resp_flags = flags_p1;

  assign rd_hit = i_mem_rdata[dbits-1] && (i_mem_rdata[TAG_LSB +: TAGW] == tag_p0);

  // Padding bits of the entry carry nothing.
  assign unused_rdata = ^i_mem_rdata[FLG_LSB-1:0];

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wena  = 1'b0;
    o_mem_wdata = '0;
    if (!i_rst) begin
      if (state == S_FLUSH) begin
        o_mem_addr = cnt;
        o_mem_wena = 1'b1;
      end else if (fill_take) begin
        o_mem_addr  = i_fill_vpn[abits-1:0];
        o_mem_wena  = 1'b1;
        o_mem_wdata = pack_entry(i_fill_vpn[vpnbits-1:abits], i_fill_ppn, i_fill_flags);
      end else if (req_take) begin
        o_mem_addr = i_req_vpn[abits-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_FLUSH;
      cnt        <= '0;
      flush_pend <= 1'b0;
      hit_p1     <= 1'b0;
      ppn_p1     <= '0;
      flags_p1   <= '0;
    end else begin
      case (state)
        S_FLUSH: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_IDLE: begin
          if (i_flush_valid || flush_pend) begin
            flush_pend <= 1'b0;
            state      <= S_FLUSH;
          end else if (!i_fill_valid && i_req_valid) begin
            state <= S_READ;
          end
        end
        // Stage p1: RAM data for the latched index is on i_mem_rdata now.
        S_READ: begin
          if (i_flush_valid) flush_pend <= 1'b1;
          hit_p1   <= rd_hit;
          ppn_p1   <= rd_hit ? i_mem_rdata[PPN_LSB +: ppnbits] : '0;
          flags_p1 <= rd_hit ? i_mem_rdata[FLG_LSB +: 8] : '0;
          state    <= S_RESP;
        end
        default: begin
          if (i_flush_valid) flush_pend <= 1'b1;
          if (i_resp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage p0: tag of the accepted lookup, compared in the following cycle.
  always_ff @(posedge i_clk) begin
    if (req_take) tag_p0 <= i_req_vpn[vpnbits-1:abits];
  end

endmodule

// File: tb/tb_tlb_mmu_ctrl.sv
// Directed bench for tlb_mmu_ctrl with a behavioural synchronous RAM attached.
module tb_tlb_mmu_ctrl;

  localparam int AB = 6;
  localparam int DB = 104;
  localparam int VB = 27;
  localparam int PB = 44;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [VB-1:0] req_vpn;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_hit;
  logic [PB-1:0] resp_ppn;
  logic [7:0]    resp_flags;
  logic          fill_valid;
  logic [VB-1:0] fill_vpn;
  logic [PB-1:0] fill_ppn;
  logic [7:0]    fill_flags;
  logic          fill_ready;
  logic          flush_valid;
  logic          flush_busy;
  logic [AB-1:0] mem_addr;
  logic          mem_wena;
  logic [DB-1:0] mem_wdata;
  logic [DB-1:0] mem_rdata;

  logic [DB-1:0] ram [0:63];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tlb_mmu_ctrl #(.abits(AB), .dbits(DB), .vpnbits(VB), .ppnbits(PB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_vpn(req_vpn), .o_req_ready(req_ready),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_hit(resp_hit), .o_resp_ppn(resp_ppn), .o_resp_flags(resp_flags),
    .i_fill_valid(fill_valid), .i_fill_vpn(fill_vpn), .i_fill_ppn(fill_ppn),
    .i_fill_flags(fill_flags), .o_fill_ready(fill_ready),
    .i_flush_valid(flush_valid), .o_flush_busy(flush_busy),
    .o_mem_addr(mem_addr), .o_mem_wena(mem_wena), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wena) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that begins the sweep; leaves just after the edge into IDLE.
  task automatic sweep_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (mem_wena !== 1'b1 || mem_addr !== AB'(i) || mem_wdata !== '0 ||
          flush_busy !== 1'b1 || req_ready !== 1'b0 || fill_ready !== 1'b0 ||
          resp_valid !== 1'b0)
        bad++;
      step();
    end
    check({tag, "_cycles"}, DB'(bad), DB'(0));
    #1;
    check({tag, "_end_wena"}, DB'(mem_wena), DB'(0));
    check({tag, "_end_busy"}, DB'(flush_busy), DB'(0));
  endtask

  task automatic fill(input logic [VB-1:0] vpn, input logic [PB-1:0] ppn, input logic [7:0] fl,
                      input logic [DB-1:0] exp_word);
    fill_valid = 1'b1; fill_vpn = vpn; fill_ppn = ppn; fill_flags = fl;
    #1;
    check("fill_ready", DB'(fill_ready), DB'(1));
    check("fill_addr", DB'(mem_addr), DB'(vpn[AB-1:0]));
    check("fill_wdata", mem_wdata, exp_word);
    step();
    fill_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [VB-1:0] vpn, input logic ehit,
                        input logic [PB-1:0] eppn, input logic [7:0] efl);
    req_valid = 1'b1; req_vpn = vpn;
    #1;
    check({tag, "_req_ready"}, DB'(req_ready), DB'(1));
    check({tag, "_rd_wena"}, DB'(mem_wena), DB'(0));
    step();
    req_valid = 1'b0;
    #1;
    check({tag, "_n1_valid"}, DB'(resp_valid), DB'(0));
    check({tag, "_n1_addr"}, DB'(mem_addr), DB'(0));
    step();
    #1;
    check({tag, "_n2_valid"}, DB'(resp_valid), DB'(1));
    check({tag, "_hit"}, DB'(resp_hit), DB'(ehit));
    check({tag, "_ppn"}, DB'(resp_ppn), DB'(eppn));
    check({tag, "_flags"}, DB'(resp_flags), DB'(efl));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    // Stale RAM contents look like valid entries for VPN tag 0x40000.
    for (int i = 0; i < 64; i++)
      ram[i] = {1'b1, 21'h40000, 18'($urandom), 32'($urandom), 32'($urandom)};
    rst = 1'b1; req_valid = 1'b0; req_vpn = '0; resp_ready = 1'b0;
    fill_valid = 1'b0; fill_vpn = '0; fill_ppn = '0; fill_flags = '0; flush_valid = 1'b0;
    step(); step(); step();
    check("rst_wena", DB'(mem_wena), DB'(0));
    check("rst_resp_valid", DB'(resp_valid), DB'(0));
    rst = 1'b0;
    sweep_check("reset_sweep");
    check("idle_req_ready", DB'(req_ready), DB'(0));

    // vpn 0x0012345: index 5, tag 0x48D.
    fill(27'h0012345, 44'hABCDE, 8'hCF, {1'b1, 21'h48D, 44'hABCDE, 8'hCF, 30'h0});
    lookup("hit1", 27'h0012345, 1'b1, 44'hABCDE, 8'hCF);
    lookup("miss1", 27'h0012385, 1'b0, 44'h0, 8'h00);

    req_valid = 1'b1; req_vpn = 27'h0012385;
    step(); req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", DB'(resp_valid), DB'(1));
      check("stall_out", DB'({resp_hit, resp_ppn, resp_flags}), DB'(0));
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
    check("stall_done_valid", DB'(resp_valid), DB'(0));

    // Overwrite index 5 with tag 0x48E.
    fill(27'h0012385, 44'h11111, 8'h03, {1'b1, 21'h48E, 44'h11111, 8'h03, 30'h0});
    lookup("ovw_new", 27'h0012385, 1'b1, 44'h11111, 8'h03);
    lookup("ovw_old", 27'h0012345, 1'b0, 44'h0, 8'h00);

    // vpn 0x1000007: index 7, tag 0x40000; fill and lookup collide.
    req_valid = 1'b1; req_vpn = 27'h1000007;
    fill_valid = 1'b1; fill_vpn = 27'h1000007; fill_ppn = 44'h123456789AB; fill_flags = 8'h5B;
    #1;
    check("coll_fill_ready", DB'(fill_ready), DB'(1));
    check("coll_req_ready", DB'(req_ready), DB'(0));
    check("coll_wena", DB'(mem_wena), DB'(1));
    step();
    fill_valid = 1'b0;
    lookup("coll_retry", 27'h1000007, 1'b1, 44'h123456789AB, 8'h5B);

    req_valid = 1'b1; req_vpn = 27'h1000007;
    step(); req_valid = 1'b0;
    step();
    flush_valid = 1'b1;
    #1;
    check("fl_resp_hit", DB'(resp_hit), DB'(1));
    check("fl_busy", DB'(flush_busy), DB'(1));
    step();
    flush_valid = 1'b0;
    #1;
    check("fl_pend_busy", DB'(flush_busy), DB'(1));
    check("fl_hold_valid", DB'(resp_valid), DB'(1));
    check("fl_hold_hit", DB'({resp_hit, resp_ppn, resp_flags}), DB'({1'b1, 44'h123456789AB, 8'h5B}));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_vpn = 27'h1000007;
    #1;
    check("fl_idle_req_ready", DB'(req_ready), DB'(0));
    check("fl_idle_wena", DB'(mem_wena), DB'(0));
    step();
    req_valid = 1'b0;
    sweep_check("flush_sweep");
    lookup("post_flush", 27'h1000007, 1'b0, 44'h0, 8'h00);

    // Reset in the middle of a sweep.
    fill(27'h1000007, 44'h77, 8'h01, {1'b1, 21'h40000, 44'h77, 8'h01, 30'h0});
    flush_valid = 1'b1;
    step();
    flush_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    #1;
    check("mid_sweep_addr", DB'(mem_addr), DB'(20));
    rst = 1'b1;
    #1;
    check("mid_sweep_rst_wena", DB'(mem_wena), DB'(0));
    step();
    rst = 1'b0;
    sweep_check("rst_sweep");

    // Reset while a lookup is in READ.
    fill(27'h1000007, 44'h99, 8'h07, {1'b1, 21'h40000, 44'h99, 8'h07, 30'h0});
    req_valid = 1'b1; req_vpn = 27'h1000007;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rd_rst_valid", DB'(resp_valid), DB'(0));
    sweep_check("rd_rst_sweep");
    lookup("after_rd_rst", 27'h1000007, 1'b0, 44'h0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
